// File: rtl/cu_seq.sv
// cu_seq: multi-cycle FETCH/DECODE/EXEC/MEM control unit with latched ALU flags.
// Optional CU_SEQ_STEP_EN adds dbg_step: FETCH idles until a step pulse is seen.
module cu_seq #(
  parameter int DATA_W = 4,
  parameter int PC_W = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
`ifdef CU_SEQ_STEP_EN
  input  logic              dbg_step,
`endif
  output logic              imem_en,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [3:0]        imem_rdata,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_z,
  input  logic              alu_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              retire,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    MEM    = 2'd3
  } state_t;

  localparam logic [3:0] OP_SWP = 4'b0000;
  localparam logic [3:0] OP_JMP = 4'b1001;
  localparam logic [3:0] OP_JZ  = 4'b1010;
  localparam logic [3:0] OP_JNZ = 4'b1011;
  localparam logic [3:0] OP_JN  = 4'b1100;
  localparam logic [3:0] OP_JNN = 4'b1101;
  localparam logic [3:0] OP_LD  = 4'b1110;
  localparam logic [3:0] OP_ST  = 4'b1111;

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] rx;
  logic [DATA_W-1:0] ry;
  logic [3:0]        ir;
  logic              zf;
  logic              nf;

  logic              go;
  logic              take;
  logic              is_swp;
  logic              is_jump;
  logic              is_mem;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   jtgt;

`ifdef CU_SEQ_STEP_EN
  assign go = dbg_step;
`else
  assign go = 1'b1;
`endif

  generate
    if (DATA_W >= PC_W) begin : g_trunc
      assign jtgt = rx[PC_W-1:0];
    end else begin : g_zext
      assign jtgt = {{(PC_W-DATA_W){1'b0}}, rx};
    end
  endgenerate

  assign pc_inc  = pc + PC_W'(1);
  assign is_swp  = (ir == OP_SWP);
  assign is_mem  = (ir == OP_LD) || (ir == OP_ST);
  assign is_jump = (ir >= OP_JMP) && (ir <= OP_JNN);

  assign imem_en   = (state == FETCH) && reset && go;
  assign imem_addr = pc;
  assign alu_op    = ir;
  assign alu_x     = rx;
  assign alu_y     = ry;
  assign mem_addr  = ry;
  assign mem_wdata = rx;
  assign state_o   = state;

  // Branch condition from the latched flags.
  always_comb begin
    take = 1'b0;
    case (ir)
      OP_JMP:  take = 1'b1;
      OP_JZ:   take = zf;
      OP_JNZ:  take = !zf;
      OP_JN:   take = nf;
      OP_JNN:  take = !nf;
      default: take = 1'b0;
    endcase
  end

  // Sequencer: state, architectural registers and registered strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      rx      <= '0;
      ry      <= '0;
      ir      <= '0;
      zf      <= 1'b0;
      nf      <= 1'b0;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      retire  <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (state)
        FETCH: begin
          if (go) state <= DECODE;
        end
        DECODE: begin
          ir    <= imem_rdata;
          state <= EXEC;
        end
        EXEC: begin
          unique case (1'b1)
            is_mem: begin
              state   <= MEM;
              mem_req <= 1'b1;
              mem_we  <= (ir == OP_ST);
            end
            is_swp: begin
              rx     <= ry;
              ry     <= rx;
              pc     <= pc_inc;
              retire <= 1'b1;
              state  <= FETCH;
            end
            is_jump: begin
              pc     <= take ? jtgt : pc_inc;
              retire <= 1'b1;
              state  <= FETCH;
            end
            default: begin
              rx     <= alu_out;
              zf     <= alu_z;
              nf     <= alu_n;
              pc     <= pc_inc;
              retire <= 1'b1;
              state  <= FETCH;
            end
          endcase
        end
        MEM: begin
          if (mem_ack) begin
            if (!mem_we) ry <= mem_rdata;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            pc      <= pc_inc;
            retire  <= 1'b1;
            state   <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cu_seq.sv
// tb_cu_seq: scoreboard bench for cu_seq with imem, ALU and
// wait-state data memory models.
module tb_cu_seq;

  logic       clk;
  logic       reset;
  logic       imem_en;
  logic [3:0] imem_addr;
  logic [3:0] imem_rdata;
  logic [3:0] alu_op;
  logic [3:0] alu_x;
  logic [3:0] alu_y;
  logic [3:0] alu_out;
  logic       alu_z;
  logic       alu_n;
  logic       mem_req;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [3:0] mem_wdata;
  logic [3:0] mem_rdata;
  logic       mem_ack;
  logic       retire;
  logic [1:0] state_o;

  int pass;
  int total;

  logic [3:0] imem [16];

  logic [3:0] m_pc;
  logic [3:0] m_rx;
  logic [3:0] m_ry;
  logic       m_zf;
  logic       m_nf;

  typedef struct {
    logic [3:0] pc;
    logic [3:0] rx;
    logic [3:0] ry;
    logic [3:0] addr;
    logic [3:0] wdata;
    logic       we;
    int         len;
    int         nreq;
  } exp_t;

  exp_t sb[$];

  cu_seq #(
    .DATA_W(4),
    .PC_W(4),
    .RESET_PC(4'd5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .imem_en(imem_en),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .alu_op(alu_op),
    .alu_x(alu_x),
    .alu_y(alu_y),
    .alu_out(alu_out),
    .alu_z(alu_z),
    .alu_n(alu_n),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .retire(retire),
    .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] alu_f(
    input logic [3:0] op,
    input logic [3:0] x,
    input logic [3:0] y
  );
    case (op)
      4'h1:    return x + 4'd1;
      4'h2:    return x + 4'd2;
      4'h3:    return x - y;
      4'h4:    return x & y;
      4'h5:    return x ^ y;
      4'h6:    return x | y;
      4'h7:    return 4'h0;
      4'h8:    return ~x;
      default: return 4'h0;
    endcase
  endfunction

  always_comb begin
    alu_out = alu_f(alu_op, alu_x, alu_y);
    alu_z   = (alu_out == 4'h0);
    alu_n   = alu_out[3];
  end

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= imem[imem_addr];
  end

  task automatic model_reset();
    m_pc = 4'd5;
    m_rx = 4'd0;
    m_ry = 4'd0;
    m_zf = 1'b0;
    m_nf = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] op, input logic [3:0] ldv);
    logic [3:0] r;
    case (op)
      4'h0: begin
        r = m_rx; m_rx = m_ry; m_ry = r;
        m_pc = m_pc + 4'd1;
      end
      4'h9: m_pc = m_rx;
      4'hA: m_pc = m_zf ? m_rx : m_pc + 4'd1;
      4'hB: m_pc = !m_zf ? m_rx : m_pc + 4'd1;
      4'hC: m_pc = m_nf ? m_rx : m_pc + 4'd1;
      4'hD: m_pc = !m_nf ? m_rx : m_pc + 4'd1;
      4'hE: begin m_ry = ldv; m_pc = m_pc + 4'd1; end
      4'hF: m_pc = m_pc + 4'd1;
      default: begin
        r = alu_f(op, m_rx, m_ry);
        m_rx = r;
        m_zf = (r == 4'h0);
        m_nf = r[3];
        m_pc = m_pc + 4'd1;
      end
    endcase
  endtask

  // Run one instruction from a FETCH cycle; checks happen at retire.
  task automatic do_instr(
    input logic [3:0] op,
    input logic [3:0] ldv,
    input int         dly,
    input bit         stray
  );
    exp_t e;
    exp_t g;
    bit   ismem;
    bit   done;
    int   cyc;
    int   reqc;
    int   memc;
    imem[m_pc] = op;
    ismem   = (op == 4'hE) || (op == 4'hF);
    e.addr  = m_ry;
    e.wdata = m_rx;
    e.we    = (op == 4'hF);
    e.len   = ismem ? 4 + dly : 3;
    e.nreq  = ismem ? dly + 1 : 0;
    model_step(op, ldv);
    e.pc = m_pc;
    e.rx = m_rx;
    e.ry = m_ry;
    sb.push_back(e);
    cyc = 0; reqc = 0; memc = 0; done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      mem_ack   = 1'b0;
      mem_rdata = ldv;
      if (retire) begin
        done = 1;
      end else if (state_o == 2'd3) begin
        if (mem_req) reqc++;
        if (memc == 0) begin
          total++;
          if ({mem_we, mem_addr} !== {e.we, e.addr})
            $display("FAIL mem_cmd op=%h we/addr=%b/%h want %b/%h",
                     op, mem_we, mem_addr, e.we, e.addr);
          else pass++;
          if (e.we) begin
            total++;
            if (mem_wdata !== e.wdata)
              $display("FAIL mem_wdata got %h want %h", mem_wdata, e.wdata);
            else pass++;
          end
        end
        if (memc == dly) mem_ack = 1'b1;
        memc++;
      end else if (stray) begin
        mem_ack = 1'b1;
      end
    end
    mem_ack = 1'b0;
    total++;
    if (!done) begin
      $display("FAIL retire_timeout op=%h no retire in %0d cycles", op, cyc);
      void'(sb.pop_front());
      return;
    end
    pass++;
    g = sb.pop_front();
    total++;
    if ({imem_addr, alu_x, alu_y} !== {g.pc, g.rx, g.ry})
      $display("FAIL arch op=%h pc/rx/ry=%h/%h/%h want %h/%h/%h",
               op, imem_addr, alu_x, alu_y, g.pc, g.rx, g.ry);
    else pass++;
    total++;
    if (cyc != g.len)
      $display("FAIL latency op=%h got %0d want %0d", op, cyc, g.len);
    else pass++;
    if (ismem) begin
      total++;
      if (reqc != g.nreq)
        $display("FAIL mem_req_len op=%h got %0d want %0d",
                 op, reqc, g.nreq);
      else pass++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({imem_addr, mem_req, retire, imem_en, state_o} !== {4'd5, 5'b0})
      $display("FAIL reset_state addr=%h req=%b ret=%b en=%b st=%0d",
               imem_addr, mem_req, retire, imem_en, state_o);
    else pass++;
    reset = 1'b1;
    #1;
    total++;
    if ({imem_en, imem_addr} !== {1'b1, 4'd5})
      $display("FAIL first_fetch en=%b addr=%h want 1/5", imem_en, imem_addr);
    else pass++;
    do_instr(4'h1, 4'h0, 0, 0);
  endtask

  task automatic test_alu();
    do_instr(4'h1, 4'h0, 0, 0);
    do_instr(4'h1, 4'h0, 0, 1);
    do_instr(4'h2, 4'h0, 0, 0);
  endtask

  task automatic test_ld_st();
    do_instr(4'hE, 4'h3, 0, 0);
    do_instr(4'hE, 4'hA, 3, 0);
    do_instr(4'hF, 4'h0, 3, 0);
  endtask

  task automatic test_swp();
    do_instr(4'hE, 4'h2, 1, 0);
    do_instr(4'h0, 4'h0, 0, 0);
    do_instr(4'hA, 4'h0, 0, 0);
    do_instr(4'hB, 4'h0, 0, 0);
  endtask

  task automatic test_jumps();
    do_instr(4'hE, 4'hC, 0, 0);
    do_instr(4'h7, 4'h0, 0, 0);
    do_instr(4'h0, 4'h0, 0, 0);
    do_instr(4'hA, 4'h0, 0, 0);
    do_instr(4'h3, 4'h0, 0, 0);
    do_instr(4'hA, 4'h0, 0, 0);
    do_instr(4'hD, 4'h0, 0, 0);
    do_instr(4'hC, 4'h0, 0, 0);
    do_instr(4'h9, 4'h0, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) do_instr(4'h1, 4'h0, 0, 1);
    do_instr(4'hA, 4'h0, 0, 0);
    do_instr(4'hD, 4'h0, 0, 0);
  endtask

  task automatic test_async_reset();
    int n;
    imem[m_pc] = 4'hE;
    n = 0;
    while (!(state_o == 2'd3 && mem_req) && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 20) begin
      $display("FAIL mem_wait_timeout state=%0d req=%b", state_o, mem_req);
    end else pass++;
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({mem_req, state_o, retire, imem_en, imem_addr} !== {5'b0, 4'd5})
      $display("FAIL async_reset req=%b st=%0d ret=%b en=%b addr=%h",
               mem_req, state_o, retire, imem_en, imem_addr);
    else pass++;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    total++;
    if ({imem_en, imem_addr} !== {1'b1, 4'd5})
      $display("FAIL restart_fetch en=%b addr=%h want 1/5",
               imem_en, imem_addr);
    else pass++;
    do_instr(4'h2, 4'h0, 0, 0);
  endtask

  initial begin
    pass      = 0;
    total     = 0;
    mem_ack   = 1'b0;
    mem_rdata = 4'h0;
    reset     = 1'b0;
    for (int i = 0; i < 16; i++) imem[i] = 4'h0;
    model_reset();
    test_reset();
    test_alu();
    test_ld_st();
    test_swp();
    test_jumps();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/cu_seq.md
Name: cu_seq

Overview:
Parametrised multi-cycle control unit; next generation of the 4-bit single-cycle CU. Sequences each instruction through explicit FETCH/DECODE/EXEC/MEM states, with configurable data and PC width and a req/ack handshake to data memory that tolerates wait states. ALU flags are latched so conditional jumps test the result of the last ALU op. Sits between instruction memory, the combinational ALU and data memory.

Parameters:
DATA_W, 4, width of rx/ry, ALU operands, data-memory address/data
PC_W, 4, program counter / instruction address width
RESET_PC, 0, PC value loaded on reset (width PC_W)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
imem_en  out  1  instruction read strobe (synchronous-read memory, 1-cycle latency)
imem_addr  out  PC_W  instruction address (= pc)
imem_rdata  in  4  opcode returned the cycle after imem_en
alu_op  out  4  current opcode (ir)
alu_x  out  DATA_W  operand x (= rx)
alu_y  out  DATA_W  operand y (= ry)
alu_out  in  DATA_W  combinational ALU result
alu_z  in  1  ALU zero flag
alu_n  in  1  ALU negative flag
mem_req  out  1  data-memory request, held until ack
mem_we  out  1  1 = store, 0 = load; valid while mem_req
mem_addr  out  DATA_W  = ry
mem_wdata  out  DATA_W  = rx
mem_rdata  in  DATA_W  load data, valid with mem_ack
mem_ack  in  1  one-cycle completion pulse
retire  out  1  one-cycle pulse when an instruction completes
state_o  out  2  FETCH=0, DECODE=1, EXEC=2, MEM=3

Behaviour:
- Reset (reset=0, async): pc=RESET_PC, rx=ry=ir=0, zf=nf=0, state=FETCH, mem_req=mem_we=retire=0, imem_en=0. First imem_en asserted the first cycle after release.
- FETCH: imem_en=1, imem_addr=pc; -> DECODE.
- DECODE: ir<=imem_rdata; -> EXEC.
- EXEC (ALU operands valid from ir/rx/ry):
  - 0000 swp: rx<=ry, ry<=rx simultaneously (no temp-register delay); flags unchanged.
  - 1001 jmp: pc<=rx[PC_W-1:0] (zero-extended if DATA_W<PC_W).
  - 1010 jz / 1011 jnz / 1100 jn / 1101 jnn: jump on latched zf / !zf / nf / !nf, else pc<=pc+1.
  - 1110 ld, 1111 st: -> MEM; pc not yet updated.
  - all other opcodes (ALU ops): rx<=alu_out, zf<=alu_z, nf<=alu_n, pc<=pc+1.
  - non-MEM opcodes: retire=1, -> FETCH.
- MEM: mem_req=1 (registered, asserted from first MEM cycle), mem_we=(ir==1111). On the cycle mem_ack=1: ld -> ry<=mem_rdata; mem_req drops next cycle; pc<=pc+1; retire=1; -> FETCH. Unbounded wait; mem_ack outside MEM ignored.
- Latency: non-memory instruction 3 cycles; ld/st 3 + (ack wait cycles + 1).
- pc arithmetic modulo 2^PC_W (pc=all-ones, non-jump -> 0). Jump target truncated to PC_W.
- Flags change only on ALU ops; swp, jumps, ld, st preserve them.
- Reset mid-instruction: all outputs to reset values immediately (mem_req falls without clock); in-flight access abandoned.

Optional Feature:
Macro CU_SEQ_STEP_EN. Defined: adds input dbg_step (1 bit); FETCH stays idle (imem_en=0) until dbg_step=1 is sampled, so exactly one instruction executes per dbg_step pulse; dbg_step during other states is ignored. Undefined: port absent, FETCH never stalls.

Test Plan:
- Reset: hold reset=0 with RESET_PC=5 -> imem_addr=5, mem_req=0, retire=0; release -> imem_en=1 next cycle, retire on 3rd cycle after that.
- ALU op: opcode 0010, rx=3, ALU model returns 5 with z=0,n=0 -> rx=5, pc+1, retire exactly 3 cycles per instruction.
- swp: rx=5, ry=2, opcode 0000 -> rx=2, ry=5 after one instruction; zf/nf unchanged.
- ld with wait: ry=0x3, mem_ack delayed 3 cycles, mem_rdata=0xA -> mem_req high 4 cycles with mem_we=0, mem_addr=3, ry=0xA, instruction length 7 cycles; st same -> mem_we=1, mem_wdata=rx.
- Conditional jumps: ALU op leaving zf=1 then jz with rx=0xC -> next imem_addr=0xC; zf=0 -> pc+1; pc=0xF non-jump -> wraps to 0.
- Async reset in MEM: drop reset between clock edges while mem_req=1 -> mem_req=0 and state_o=0 before next edge; restart fetches RESET_PC.
